bw_io_pm_ctl: RTL and testbench

Core-side performance-monitor controller for the PMI/PMO miscellaneous pad pair. It synchronizes the asynchronous trigger from the PMI pad (`io_pmi`) and counts core event pulses. On each PMI trigger it snapshots the count and serializes it as a framed bit stream onto `io_pmo`. It also owns the PMO pad output enable `pcm_misc_oe`, and sits directly upstream of the PMI/PMO cmos2 pads.

---
 rtl/bw_io_pm_ctl.sv | 192 +++++++++++++++++++
 tb/tb_bw_io_pm_ctl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bw_io_pm_ctl.sv
// Performance-monitor controller for the PMI/PMO pad pair: synchronizes PMI triggers,
// counts events and serializes count snapshots onto PMO. Parity bit enabled by PM_PARITY_EN.
module bw_io_pm_ctl #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pm_en,
    input  logic pm_event,
    input  logic io_pmi,
    input  logic pm_ovr_clr,
    output logic io_pmo,
    output logic pcm_misc_oe,
    output logic pm_busy,
    output logic pm_overrun
);

    localparam int unsigned BCW = $clog2(CNT_W + 1);

`ifdef PM_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SHIFT = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SHIFT = 3'd2,
        ST_STOP  = 3'd4
    } state_e;
`endif

    state_e             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               edge_q;
    logic               trig_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   sh_q, sh_d;
    logic [BCW-1:0]     bcnt_q, bcnt_d;
    logic               pend_q, pend_d;
    logic               io_pmo_q, io_pmo_d;
    logic               oe_q;
    logic               busy_q;
    logic               ovr_q;
    logic               trig_v;
    logic               snap;
    logic               drop;
`ifdef PM_PARITY_EN
    logic               par_q, par_d;
`endif

    // PMI synchronizer and registered rising-edge detect; all-ones reset masks a held-high PMI
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            edge_q <= 1'b1;
            trig_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], io_pmi};
            edge_q <= sync_q[SYNC_STAGES-1];
            trig_q <= sync_q[SYNC_STAGES-1] & ~edge_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sh_q     <= '0;
            bcnt_q   <= '0;
            pend_q   <= 1'b0;
            io_pmo_q <= 1'b0;
            oe_q     <= 1'b0;
            busy_q   <= 1'b0;
            ovr_q    <= 1'b0;
`ifdef PM_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            bcnt_q   <= bcnt_d;
            pend_q   <= pend_d;
            io_pmo_q <= io_pmo_d;
            oe_q     <= pm_en;
            busy_q   <= (state_d != ST_IDLE);
            ovr_q    <= drop | (ovr_q & ~pm_ovr_clr);
`ifdef PM_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        bcnt_d   = bcnt_q;
        pend_d   = pend_q;
        io_pmo_d = 1'b0;
        snap     = 1'b0;
        drop     = 1'b0;
        trig_v   = trig_q & pm_en;
`ifdef PM_PARITY_EN
        par_d    = par_q;
`endif

        // One-deep pending queue; a trigger beyond it is lost and flagged
        if (trig_v && (state_q != ST_IDLE)) begin
            if (pend_q) begin
                drop = 1'b1;
            end else begin
                pend_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (trig_v || pend_q) begin
                    state_d = ST_START;
                    snap    = 1'b1;
                end
            end
            ST_START: state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (bcnt_q == BCW'(CNT_W)) begin
`ifdef PM_PARITY_EN
                    state_d = ST_PAR;
`else
                    state_d = ST_STOP;
`endif
                end
            end
`ifdef PM_PARITY_EN
            ST_PAR:   state_d = ST_STOP;
`endif
            ST_STOP: begin
                if (pend_q) begin
                    state_d = ST_START;
                    snap    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase

        if (!pm_en) begin
            state_d = ST_IDLE;
            snap    = 1'b0;
            pend_d  = 1'b0;
        end

        // An event in the snapshot cycle belongs to the new window
        if (snap) begin
            sh_d   = cnt_q;
            bcnt_d = '0;
            pend_d = 1'b0;
            cnt_d  = CNT_W'(pm_event);
`ifdef PM_PARITY_EN
            par_d  = ^cnt_q;
`endif
        end else if (pm_en && pm_event && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_d)
            ST_START: io_pmo_d = 1'b1;
            ST_SHIFT: begin
                io_pmo_d = sh_q[CNT_W-1];
                sh_d     = {sh_q[CNT_W-2:0], 1'b0};
                bcnt_d   = bcnt_q + BCW'(1);
            end
`ifdef PM_PARITY_EN
            ST_PAR:   io_pmo_d = par_q;
`endif
            default:  io_pmo_d = 1'b0;
        endcase
    end

    assign io_pmo      = io_pmo_q;
    assign pcm_misc_oe = oe_q;
    assign pm_busy     = busy_q;
    assign pm_overrun  = ovr_q;

endmodule

// File: tb/tb_bw_io_pm_ctl.sv
// Directed self-checking bench for bw_io_pm_ctl (CNT_W=16, SYNC_STAGES=2).
module tb_bw_io_pm_ctl;

    localparam int unsigned CW = 16;

    logic clk;
    logic rst;
    logic pm_en;
    logic pm_event;
    logic io_pmi;
    logic pm_ovr_clr;
    logic io_pmo;
    logic pcm_misc_oe;
    logic pm_busy;
    logic pm_overrun;

    int errors = 0;
    int checks = 0;

    bw_io_pm_ctl #(.CNT_W(CW), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .pm_en       (pm_en),
        .pm_event    (pm_event),
        .io_pmi      (io_pmi),
        .pm_ovr_clr  (pm_ovr_clr),
        .io_pmo      (io_pmo),
        .pcm_misc_oe (pcm_misc_oe),
        .pm_busy     (pm_busy),
        .pm_overrun  (pm_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef PM_PARITY_EN
    localparam int FRAME_LEN = CW + 3;
`else
    localparam int FRAME_LEN = CW + 2;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            pm_event = 1'b1;
            step();
            pm_event = 1'b0;
            step();
        end
    endtask

    // Produces a clean PMI rise; returns in the trigger cycle T
    task automatic pmi_rise();
        io_pmi = 1'b0;
        repeat (3) step();
        io_pmi = 1'b1;
        repeat (3) step();
    endtask

    // Collects data bits, optional parity bit and the stop bit following a START cycle
    task automatic capture_body(output logic [CW-1:0] data, output logic par,
                                output logic stop_bit, output int nbusy);
        nbusy = 0;
        data  = '0;
        par   = 1'b0;
        for (int i = CW - 1; i >= 0; i--) begin
            step();
            data[i] = io_pmo;
            if (pm_busy) nbusy++;
        end
`ifdef PM_PARITY_EN
        step();
        par = io_pmo;
        if (pm_busy) nbusy++;
`endif
        step();
        stop_bit = io_pmo;
        if (pm_busy) nbusy++;
    endtask

    task automatic test_reset();
        logic bad;
        rst = 1'b1; pm_en = 1'b0; pm_event = 1'b0; io_pmi = 1'b1; pm_ovr_clr = 1'b0;
        repeat (3) step();
        checks++;
        if ({io_pmo, pcm_misc_oe, pm_busy, pm_overrun} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000", {io_pmo, pcm_misc_oe, pm_busy, pm_overrun});
        end
        rst = 1'b0; pm_en = 1'b1;
        step();
        checks++;
        if (pcm_misc_oe !== 1'b1) begin
            errors++;
            $display("FAIL oe_follow_en: got %b expected 1", pcm_misc_oe);
        end
        bad = 1'b0;
        repeat (8) begin
            step();
            if (io_pmo !== 1'b0 || pm_busy !== 1'b0 || pm_overrun !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL held_pmi_no_frame: got activity=%b expected 0", bad);
        end
    endtask

    task automatic test_basic_frame();
        logic [CW-1:0] d; logic p; logic s; int nb;
        io_pmi = 1'b0;
        repeat (4) step();
        pulses(5);
        io_pmi = 1'b1;
        repeat (3) step();
        checks++;
        if (io_pmo !== 1'b0 || pm_busy !== 1'b0) begin
            errors++;
            $display("FAIL pre_start: got pmo=%b busy=%b expected 0 0", io_pmo, pm_busy);
        end
        step();
        checks++;
        if (io_pmo !== 1'b1 || pm_busy !== 1'b1) begin
            errors++;
            $display("FAIL start_bit: got pmo=%b busy=%b expected 1 1", io_pmo, pm_busy);
        end
        capture_body(d, p, s, nb);
        checks++;
        if (d !== 16'h0005) begin
            errors++;
            $display("FAIL frame_data_5: got %h expected 0005", d);
        end
        checks++;
        if (s !== 1'b0) begin
            errors++;
            $display("FAIL stop_bit: got %b expected 0", s);
        end
        step();
        checks++;
        if (nb + 1 !== FRAME_LEN || pm_busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_len: got %0d (busy after=%b) expected %0d (0)", nb + 1, pm_busy, FRAME_LEN);
        end
    endtask

    task automatic test_saturation();
        logic [CW-1:0] d; logic p; logic s; int nb;
        pm_event = 1'b1;
        io_pmi = 1'b0;
        repeat (70000) step();
        io_pmi = 1'b1;
        repeat (3) step();
        step();
        pm_event = 1'b0;
        checks++;
        if (io_pmo !== 1'b1) begin
            errors++;
            $display("FAIL sat_start: got %b expected 1", io_pmo);
        end
        capture_body(d, p, s, nb);
        checks++;
        if (d !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_data: got %h expected ffff", d);
        end
        step();
        pmi_rise();
        step();
        capture_body(d, p, s, nb);
        checks++;
        if (d !== 16'h0001) begin
            errors++;
            $display("FAIL restart_at_one: got %h expected 0001", d);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [CW-1:0] d; logic p; logic s; int nb; logic bad;
        pulses(3);
        pmi_rise();
        step();
        pm_event = 1'b1;
        for (int k = 0; k < 3; k++) begin
            io_pmi = 1'b0;
            repeat (2) step();
            io_pmi = 1'b1;
            repeat (2) step();
        end
        pm_event = 1'b0;
        checks++;
        if (pm_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %b expected 1", pm_overrun);
        end
        repeat (CW + 2 - 13) step();
        checks++;
        if (io_pmo !== 1'b0 || pm_busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_stop: got pmo=%b busy=%b expected 0 1", io_pmo, pm_busy);
        end
        step();
        checks++;
        if (io_pmo !== 1'b1 || pm_busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_start: got pmo=%b busy=%b expected 1 1", io_pmo, pm_busy);
        end
        capture_body(d, p, s, nb);
        checks++;
        if (d !== 16'h000C) begin
            errors++;
            $display("FAIL b2b_data: got %h expected 000c", d);
        end
        bad = 1'b0;
        repeat (6) begin
            step();
            if (pm_busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL single_followon: got extra_busy=%b expected 0", bad);
        end
        checks++;
        if (pm_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: got %b expected 1", pm_overrun);
        end
        pm_ovr_clr = 1'b1;
        step();
        pm_ovr_clr = 1'b0;
        checks++;
        if (pm_overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: got %b expected 0", pm_overrun);
        end
    endtask

    task automatic test_disable();
        logic [CW-1:0] d; logic p; logic s; int nb; logic bad;
        pulses(6);
        pmi_rise();
        step();
        pm_event = 1'b1;
        repeat (9) step();
        pm_event = 1'b0;
        pm_en = 1'b0;
        step();
        checks++;
        if ({io_pmo, pcm_misc_oe, pm_busy} !== 3'b000) begin
            errors++;
            $display("FAIL disable_idle: got pmo/oe/busy=%b expected 000", {io_pmo, pcm_misc_oe, pm_busy});
        end
        pulses(3);
        bad = 1'b0;
        io_pmi = 1'b0;
        repeat (3) step();
        io_pmi = 1'b1;
        repeat (6) begin
            step();
            if (pm_busy !== 1'b0 || pm_overrun !== 1'b0 || io_pmo !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL disabled_trigger_ignored: got activity=%b expected 0", bad);
        end
        pm_en = 1'b1;
        step();
        checks++;
        if (pcm_misc_oe !== 1'b1 || pm_busy !== 1'b0) begin
            errors++;
            $display("FAIL reenable: got oe=%b busy=%b expected 1 0", pcm_misc_oe, pm_busy);
        end
        pmi_rise();
        step();
        capture_body(d, p, s, nb);
        checks++;
        if (d !== 16'h0009) begin
            errors++;
            $display("FAIL held_count: got %h expected 0009", d);
        end
        step();
    endtask

    task automatic test_parity();
        logic [CW-1:0] d; logic p; logic s; int nb;
        pulses(7);
        pmi_rise();
        step();
        capture_body(d, p, s, nb);
        checks++;
        if (d !== 16'h0007 || s !== 1'b0) begin
            errors++;
            $display("FAIL par_frame: got data=%h stop=%b expected 0007 0", d, s);
        end
`ifdef PM_PARITY_EN
        checks++;
        if (p !== 1'b1) begin
            errors++;
            $display("FAIL par_bit: got %b expected 1", p);
        end
`endif
        step();
        checks++;
        if (nb + 1 !== FRAME_LEN || pm_busy !== 1'b0) begin
            errors++;
            $display("FAIL par_len: got %0d expected %0d", nb + 1, FRAME_LEN);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic bad;
        pulses(2);
        pmi_rise();
        step();
        repeat (5) step();
        rst = 1'b1;
        step();
        checks++;
        if ({io_pmo, pcm_misc_oe, pm_busy, pm_overrun} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_frame: got %b expected 0000", {io_pmo, pcm_misc_oe, pm_busy, pm_overrun});
        end
        rst = 1'b0;
        bad = 1'b0;
        repeat (8) begin
            step();
            if (pm_busy !== 1'b0 || io_pmo !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0 || pcm_misc_oe !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_quiet: got activity=%b oe=%b expected 0 1", bad, pcm_misc_oe);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_saturation();
        test_back_to_back();
        test_disable();
        test_parity();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
